// File: rtl/plab4_net_router_input_ctrl_if.sv
// rtl/plab4_net_router_input_ctrl_if.sv - router input port handshake bundle
interface plab4_net_router_input_ctrl_if #(
    parameter int p_msg_nbits = 44
);
    logic                   in_domain;
    logic                   in_val;
    logic                   in_rdy;
    logic [p_msg_nbits-1:0] in_msg;
    logic [2:0]             reqs;
    logic [2:0]             grants;
    logic [p_msg_nbits-1:0] out_msg;
    logic [2:0]             num_free;

    modport master (
        output in_domain, in_val, in_msg, grants,
        input  in_rdy, reqs, out_msg, num_free
    );

    modport slave (
        input  in_domain, in_val, in_msg, grants,
        output in_rdy, reqs, out_msg, num_free
    );
endinterface

// File: rtl/plab4_net_router_input_ctrl.sv
// rtl/plab4_net_router_input_ctrl.sv - ring router input buffer, route compute and grant-driven dequeue
module plab4_net_router_input_ctrl #(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 4,
    parameter int p_msg_nbits   = 44,
    parameter int p_dest_lsb    = 40,
    parameter int p_num_entries = 2,
    parameter int p_oneway      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    plab4_net_router_input_ctrl_if.slave  bus
);
    localparam int          DW   = $clog2(p_num_routers);
    localparam int          PW   = $clog2(p_num_entries);
    localparam int unsigned HALF = p_num_routers / 2;
    localparam logic [2:0]  NE   = 3'(p_num_entries);

    logic [p_msg_nbits-1:0] r_entries [p_num_entries];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [2:0]             r_count;
    logic                   r_rdy_en;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_rdy;
    logic                   w_enq;
    logic                   w_deq;
    logic [p_msg_nbits-1:0] w_head;
    logic [DW-1:0]          w_dest;
    logic [DW-1:0]          w_dist;
    logic [2:0]             w_reqs;

    assign w_full  = (r_count == NE);
    assign w_empty = (r_count == 3'd0);
    // No bypass: readiness depends only on the registered count.
    assign w_rdy   = r_rdy_en & ~w_full;
    assign w_enq   = bus.in_val & w_rdy;
    assign w_head  = w_empty ? '0 : r_entries[r_rd_ptr];
    assign w_dest  = w_head[p_dest_lsb +: DW];
    assign w_dist  = w_dest - DW'(p_router_id);
    assign w_deq   = |(w_reqs & bus.grants);

    always_comb begin
        w_reqs = 3'b000;
        if (!w_empty) begin
            if (w_dist == '0)
                w_reqs = 3'b010;
            else if ((p_oneway != 0) || (32'(w_dist) <= HALF))
                w_reqs = 3'b100;
            else
                w_reqs = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_enq)
            r_entries[r_wr_ptr] <= bus.in_msg;
    end

    assign bus.in_rdy   = w_rdy;
    assign bus.reqs     = w_reqs;
    assign bus.out_msg  = w_head;
    assign bus.num_free = NE - r_count;
endmodule

// File: tb/tb_plab4_net_router_input_ctrl.sv
// tb/tb_plab4_net_router_input_ctrl.sv - self-checking bench for plab4_net_router_input_ctrl
module tb_plab4_net_router_input_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    plab4_net_router_input_ctrl_if #(.p_msg_nbits(44)) if0 ();
    plab4_net_router_input_ctrl_if #(.p_msg_nbits(44)) if1 ();
    plab4_net_router_input_ctrl_if #(.p_msg_nbits(44)) if2 ();

    plab4_net_router_input_ctrl #(.p_router_id(0), .p_num_routers(4), .p_msg_nbits(44),
        .p_dest_lsb(40), .p_num_entries(2), .p_oneway(0))
        dut0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
    plab4_net_router_input_ctrl #(.p_router_id(1), .p_num_routers(4), .p_msg_nbits(44),
        .p_dest_lsb(40), .p_num_entries(2), .p_oneway(0))
        dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
    plab4_net_router_input_ctrl #(.p_router_id(1), .p_num_routers(4), .p_msg_nbits(44),
        .p_dest_lsb(40), .p_num_entries(2), .p_oneway(1))
        dut2 (.clk(clk), .reset(rst_n), .bus(if2.slave));

    int checks   = 0;
    int failures = 0;

    logic [43:0] sb[$];
    bit          sb_en  = 1'b0;
    bit          mon_on = 1'b0;

    function automatic logic [43:0] mk(int dest, int tag);
        logic [1:0] dd;
        dd = 2'(dest);
        return {2'b00, dd, 8'hA5, tag};
    endfunction

    function automatic logic [2:0] route(logic [43:0] m, int id, bit ow);
        logic [1:0] d;
        d = m[41:40] - 2'(id);
        if (d == 2'd0) return 3'b010;
        if (ow || int'(d) <= 2) return 3'b100;
        return 3'b001;
    endfunction

    // Reference queue for dut0: updated on each clock, compared mid-cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            sb_en = 1'b0;
        end else begin
            logic       rdy;
            logic [2:0] hreq;
            rdy  = sb_en && (sb.size() < 2);
            hreq = (sb.size() > 0) ? route(sb[0], 0, 1'b0) : 3'b000;
            if ((hreq & if0.grants) != 3'b000)
                void'(sb.pop_front());
            if (if0.in_val && rdy)
                sb.push_back(if0.in_msg);
            sb_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            logic        e_rdy;
            logic [43:0] e_msg;
            logic [2:0]  e_req;
            logic [2:0]  e_free;
            e_rdy  = rst_n && sb_en && (sb.size() < 2);
            e_msg  = (sb.size() > 0) ? sb[0] : 44'd0;
            e_req  = (sb.size() > 0) ? route(sb[0], 0, 1'b0) : 3'b000;
            e_free = 3'(2 - sb.size());
            checks += 4;
            if (if0.in_rdy !== e_rdy) begin
                failures++;
                $display("FAIL sb_in_rdy t=%0t got=%b exp=%b", $time, if0.in_rdy, e_rdy);
            end
            if (if0.out_msg !== e_msg) begin
                failures++;
                $display("FAIL sb_out_msg t=%0t got=%h exp=%h", $time, if0.out_msg, e_msg);
            end
            if (if0.reqs !== e_req) begin
                failures++;
                $display("FAIL sb_reqs t=%0t got=%b exp=%b", $time, if0.reqs, e_req);
            end
            if (if0.num_free !== e_free) begin
                failures++;
                $display("FAIL sb_num_free t=%0t got=%0d exp=%0d", $time, if0.num_free, e_free);
            end
        end
    end

    task automatic drive0(bit v, logic [43:0] msg, logic [2:0] g);
        if0.in_val = v;
        if0.in_msg = msg;
        if0.grants = g;
        @(posedge clk); #1;
        if0.in_val = 1'b0;
        if0.in_msg = '0;
        if0.grants = 3'b000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks += 4;
        if (if0.in_rdy !== 1'b0) begin failures++; $display("FAIL rst_in_rdy got=%b exp=0", if0.in_rdy); end
        if (if0.reqs !== 3'b000) begin failures++; $display("FAIL rst_reqs got=%b exp=000", if0.reqs); end
        if (if0.num_free !== 3'd2) begin failures++; $display("FAIL rst_num_free got=%0d exp=2", if0.num_free); end
        if (if0.out_msg !== 44'd0) begin failures++; $display("FAIL rst_out_msg got=%h exp=0", if0.out_msg); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if0.in_rdy !== 1'b1) begin failures++; $display("FAIL rst_release_rdy got=%b exp=1", if0.in_rdy); end
    endtask

    task automatic test_local();
        drive0(1'b1, mk(0, 1), 3'b000);
        checks += 2;
        if (if0.reqs !== 3'b010) begin failures++; $display("FAIL local_reqs got=%b exp=010", if0.reqs); end
        if (if0.out_msg !== mk(0, 1)) begin failures++; $display("FAIL local_msg got=%h exp=%h", if0.out_msg, mk(0, 1)); end
        drive0(1'b0, '0, 3'b010);
        checks += 2;
        if (if0.reqs !== 3'b000) begin failures++; $display("FAIL local_deq_reqs got=%b exp=000", if0.reqs); end
        if (if0.num_free !== 3'd2) begin failures++; $display("FAIL local_deq_free got=%0d exp=2", if0.num_free); end
    endtask

    task automatic test_routing();
        int         dests [3] = '{2, 3, 0};
        logic [2:0] exp1  [3] = '{3'b100, 3'b100, 3'b001};
        for (int i = 0; i < 3; i++) begin
            if1.in_val = 1'b1; if1.in_msg = mk(dests[i], 50 + i);
            if2.in_val = 1'b1; if2.in_msg = mk(dests[i], 50 + i);
            @(posedge clk); #1;
            if1.in_val = 1'b0; if2.in_val = 1'b0;
            checks += 2;
            if (if1.reqs !== exp1[i]) begin failures++; $display("FAIL route_twoway dest=%0d got=%b exp=%b", dests[i], if1.reqs, exp1[i]); end
            if (if2.reqs !== 3'b100) begin failures++; $display("FAIL route_oneway dest=%0d got=%b exp=100", dests[i], if2.reqs); end
            if1.grants = exp1[i];
            if2.grants = 3'b100;
            @(posedge clk); #1;
            if1.grants = 3'b000; if2.grants = 3'b000;
            checks += 2;
            if (if1.num_free !== 3'd2) begin failures++; $display("FAIL route_twoway_deq got=%0d exp=2", if1.num_free); end
            if (if2.num_free !== 3'd2) begin failures++; $display("FAIL route_oneway_deq got=%0d exp=2", if2.num_free); end
        end
    endtask

    task automatic test_full();
        drive0(1'b1, mk(1, 10), 3'b000);
        drive0(1'b1, mk(3, 11), 3'b000);
        checks += 2;
        if (if0.in_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy got=%b exp=0", if0.in_rdy); end
        if (if0.num_free !== 3'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", if0.num_free); end
        drive0(1'b1, mk(2, 12), 3'b000);
        checks++;
        if (if0.out_msg !== mk(1, 10)) begin failures++; $display("FAIL full_head got=%h exp=%h", if0.out_msg, mk(1, 10)); end
        // Dequeue while offering a new message: full means it is still refused.
        drive0(1'b1, mk(2, 13), 3'b100);
        checks += 2;
        if (if0.in_rdy !== 1'b1) begin failures++; $display("FAIL full_release_rdy got=%b exp=1", if0.in_rdy); end
        if (if0.out_msg !== mk(3, 11)) begin failures++; $display("FAIL full_order got=%h exp=%h", if0.out_msg, mk(3, 11)); end
        drive0(1'b0, '0, 3'b001);
        checks++;
        if (if0.num_free !== 3'd2) begin failures++; $display("FAIL full_drain got=%0d exp=2", if0.num_free); end
    endtask

    task automatic test_back_to_back();
        logic [43:0] head;
        logic [43:0] nxt;
        head = mk(2, 100);
        drive0(1'b1, head, 3'b000);
        for (int i = 0; i < 5; i++) begin
            nxt = mk(i % 4, 200 + i);
            drive0(1'b1, nxt, route(head, 0, 1'b0));
            checks += 2;
            if (if0.num_free !== 3'd1) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, if0.num_free); end
            if (if0.out_msg !== nxt) begin failures++; $display("FAIL b2b_head i=%0d got=%h exp=%h", i, if0.out_msg, nxt); end
            head = nxt;
        end
        drive0(1'b0, '0, route(head, 0, 1'b0));
    endtask

    task automatic test_mismatch();
        drive0(1'b1, mk(1, 300), 3'b000);
        drive0(1'b0, '0, 3'b001);
        drive0(1'b0, '0, 3'b011);
        checks += 2;
        if (if0.num_free !== 3'd1) begin failures++; $display("FAIL mismatch_free got=%0d exp=1", if0.num_free); end
        if (if0.reqs !== 3'b100) begin failures++; $display("FAIL mismatch_reqs got=%b exp=100", if0.reqs); end
        drive0(1'b1, mk(3, 301), 3'b000);
        drive0(1'b0, '0, 3'b111);
        checks += 2;
        if (if0.num_free !== 3'd1) begin failures++; $display("FAIL multigrant_free got=%0d exp=1", if0.num_free); end
        if (if0.out_msg !== mk(3, 301)) begin failures++; $display("FAIL multigrant_head got=%h exp=%h", if0.out_msg, mk(3, 301)); end
        drive0(1'b1, mk(0, 302), 3'b000);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (if0.reqs !== 3'b000) begin failures++; $display("FAIL async_rst_reqs got=%b exp=000", if0.reqs); end
        if (if0.num_free !== 3'd2) begin failures++; $display("FAIL async_rst_free got=%0d exp=2", if0.num_free); end
        if (if0.out_msg !== 44'd0) begin failures++; $display("FAIL async_rst_msg got=%h exp=0", if0.out_msg); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        if0.in_domain = 1'b0; if0.in_val = 1'b0; if0.in_msg = '0; if0.grants = 3'b000;
        if1.in_domain = 1'b0; if1.in_val = 1'b0; if1.in_msg = '0; if1.grants = 3'b000;
        if2.in_domain = 1'b1; if2.in_val = 1'b0; if2.in_msg = '0; if2.grants = 3'b000;
        #1 rst_n = 1'b0;
        #1 mon_on = 1'b1;
        test_reset();
        test_local();
        test_routing();
        test_full();
        test_back_to_back();
        test_mismatch();
        repeat (2) @(posedge clk);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plab4_net_router_input_ctrl.md
Name: plab4_net_router_input_ctrl

Overview:
Input-side controller for one router input port in the ring network; the counterpart of the per-output arbiter control.
- Buffers arriving messages in a small FIFO.
- Computes the route for the head message from its destination field.
- Drives a one-hot request to the three output controls and dequeues on grant.
- Its reqs/grants pair with the output controls' reqs/grants; its head message feeds the crossbar data input.

Parameters:
p_router_id, 0, this router's index (0..p_num_routers-1)
p_num_routers, 4, routers on the ring (power of two, >=2)
p_msg_nbits, 44, message width
p_dest_lsb, 40, LSB of destination field inside message; field width = clog2(p_num_routers)
p_num_entries, 2, FIFO depth (2 or 4)
p_oneway, 0, 1 = all non-local traffic routed to output 2 only

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_domain  input  1  security domain of this input port (labels reqs/msg/handshake)
in_val  input  1  upstream message valid
in_rdy  output  1  buffer can accept
in_msg  input  p_msg_nbits  upstream message
reqs  output  3  one-hot request: bit0 = west/prev, bit1 = terminal, bit2 = east/next
grants  input  3  bit i = output i granted this input this cycle
out_msg  output  p_msg_nbits  head-of-FIFO message to crossbar
num_free  output  3  free FIFO entries

Behaviour:
- Reset (reset==0, async):
  - FIFO empty; rd/wr pointers 0.
  - in_rdy=0, reqs=0, num_free=p_num_entries, out_msg=0.
  - After reset deasserts: in_rdy=1 on the first cycle.
- Enqueue: on posedge when in_val & in_rdy; in_msg is written at wr_ptr; wr_ptr wraps modulo p_num_entries.
- in_rdy = (count != p_num_entries). No bypass: when full, in_rdy=0 even if a dequeue occurs that cycle.
- Head: out_msg = entry[rd_ptr] when count>0, else 0. Minimum latency in_val to reqs is 1 cycle.
- Route, combinational from head:
  - d = (dest - p_router_id) mod p_num_routers, computed in dest-field width with natural wrap.
  - d==0 -> reqs=3'b010.
  - Else if p_oneway or d <= p_num_routers/2 -> 3'b100 (ties go east).
  - Else -> 3'b001.
  - count==0 -> reqs=3'b000.
- Dequeue: on posedge when (reqs & grants) != 0; rd_ptr advances with wrap.
  - Grant bits not matching reqs are ignored.
  - More than one grant bit set is illegal; it still dequeues exactly one entry.
- Simultaneous enq+deq (not full): count unchanged, both pointers advance.
- Count: 0..p_num_entries; num_free = p_num_entries - count.
- Reset mid-operation: buffered messages are discarded; outputs return to reset values immediately (async).
- reqs held stable while ungranted (head does not change without dequeue).

Test Plan:
- Reset then idle: reset low 3 cycles -> in_rdy=0, reqs=0, num_free=2; one cycle after release -> in_rdy=1.
- Local delivery, id=0, N=4: enqueue msg dest=0 -> next cycle reqs=3'b010; grants=3'b010 -> following cycle reqs=0, num_free=2.
- Routing, id=1, N=4, p_oneway=0: dest=2 -> reqs=3'b100; dest=3 (d=2, tie) -> 3'b100; dest=0 (d=3) -> 3'b001. Same dests with p_oneway=1 -> all 3'b100.
- Full/back-pressure: 2 enqueues, grants=0 -> in_rdy=0, num_free=0. Apply in_val with new msg -> not accepted. Grant head -> in_rdy=1 next cycle; FIFO order preserved.
- Simultaneous enq+deq with count=1: in_val=1, grants matching -> count stays 1, out_msg becomes the newly enqueued msg; wrap over 5 iterations shows no loss or duplication.
- Mismatched grant: head reqs=3'b100, grants=3'b001 -> no dequeue. Async reset asserted mid-cycle with 2 entries -> reqs=0 immediately, num_free=2.
